// File: rtl/raster_collision_if.sv
// rtl/raster_collision_if.sv - raster sample and collision result bundle
interface raster_collision_if;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        blank_n;
    logic        ball_on;
    logic        brick_on;
    logic        paddle_on;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic        refresh_tick;
    logic        brick_hit;
    logic [9:0]  hit_x;
    logic [8:0]  hit_y;
    logic        brick_h_hit;
    logic        brick_v_hit;
    logic        paddle_hit;
    logic [7:0]  hit_total;

    modport master (
        output pixel_x, pixel_y, blank_n, ball_on, brick_on, paddle_on,
               ball_x, ball_y, refresh_tick,
        input  brick_hit, hit_x, hit_y, brick_h_hit, brick_v_hit,
               paddle_hit, hit_total
    );

    modport slave (
        input  pixel_x, pixel_y, blank_n, ball_on, brick_on, paddle_on,
               ball_x, ball_y, refresh_tick,
        output brick_hit, hit_x, hit_y, brick_h_hit, brick_v_hit,
               paddle_hit, hit_total
    );
endinterface

// File: rtl/raster_collision.sv
// rtl/raster_collision.sv - ball/brick/paddle overlap detector, one brick hit per move window
module raster_collision #(
    parameter int BALL_W = 8,
    parameter int BALL_H = 7
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    raster_collision_if.slave   rc
);
    typedef enum logic {ARMED, LOCKED} state_t;

    state_t      state, state_d;
    logic        hit_d;

    logic        s1_ov_brick, s1_ov_pad, s1_h, s1_v;
    logic [9:0]  s1_x;
    logic [8:0]  s1_y;

    logic        brick_hit_q, h_hit_q, v_hit_q, pad_hit_q;
    logic [9:0]  hit_x_q;
    logic [8:0]  hit_y_q;
    logic [7:0]  total_q;

    logic [10:0] ball_right;
    logic [9:0]  ball_bottom;
    logic        tag_h, tag_v, h_d, v_d;

    assign ball_right  = rc.ball_x + 11'(BALL_W - 1);
    assign ball_bottom = rc.ball_y + 10'(BALL_H - 1);
    assign tag_h = ({1'b0, rc.pixel_x} == rc.ball_x) || ({1'b0, rc.pixel_x} == ball_right);
    assign tag_v = ({1'b0, rc.pixel_y} == rc.ball_y) || ({1'b0, rc.pixel_y} == ball_bottom);

    assign h_d = s1_ov_brick & s1_h;
    assign v_d = s1_ov_brick & s1_v;

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= ARMED;
        else
            state <= state_d;
    end

    // A refresh_tick re-arms in the same cycle, so a coincident overlap opens the new window.
    always_comb begin
        state_d = state;
        hit_d   = 1'b0;
        if (rc.refresh_tick)
            state_d = ARMED;
        if ((state == ARMED || rc.refresh_tick) && s1_ov_brick) begin
            hit_d   = 1'b1;
            state_d = LOCKED;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_ov_brick <= 1'b0;
            s1_ov_pad   <= 1'b0;
            s1_h        <= 1'b0;
            s1_v        <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            brick_hit_q <= 1'b0;
            h_hit_q     <= 1'b0;
            v_hit_q     <= 1'b0;
            pad_hit_q   <= 1'b0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
            total_q     <= '0;
        end else begin
            s1_ov_brick <= rc.blank_n & rc.ball_on & rc.brick_on;
            s1_ov_pad   <= rc.blank_n & rc.ball_on & rc.paddle_on;
            s1_h        <= tag_h;
            s1_v        <= tag_v;
            s1_x        <= rc.pixel_x;
            s1_y        <= rc.pixel_y;
            brick_hit_q <= hit_d;
            if (hit_d) begin
                hit_x_q <= s1_x;
                hit_y_q <= s1_y;
                if (total_q != 8'hFF)
                    total_q <= total_q + 8'd1;
            end
            if (rc.refresh_tick) begin
                h_hit_q   <= h_d;
                v_hit_q   <= v_d;
                pad_hit_q <= s1_ov_pad;
            end else begin
                h_hit_q   <= h_hit_q | h_d;
                v_hit_q   <= v_hit_q | v_d;
                pad_hit_q <= pad_hit_q | s1_ov_pad;
            end
        end
    end

    assign rc.brick_hit   = brick_hit_q;
    assign rc.hit_x       = hit_x_q;
    assign rc.hit_y       = hit_y_q;
    assign rc.brick_h_hit = h_hit_q;
    assign rc.brick_v_hit = v_hit_q;
    assign rc.paddle_hit  = pad_hit_q;
    assign rc.hit_total   = total_q;
endmodule

// File: tb/tb_raster_collision.sv
// tb/tb_raster_collision.sv - directed-vector bench for raster_collision
module tb_raster_collision;
    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_total;

    raster_collision_if rc();

    raster_collision #(.BALL_W(8), .BALL_H(7)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .rc       (rc.slave)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic [9:0] x, input logic [8:0] y, input logic bl,
                        input logic ba, input logic br, input logic pa, input logic tk);
        rc.pixel_x      = x;
        rc.pixel_y      = y;
        rc.blank_n      = bl;
        rc.ball_on      = ba;
        rc.brick_on     = br;
        rc.paddle_on    = pa;
        rc.refresh_tick = tk;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle(input logic tk);
        step(10'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, tk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hit"},   32'(rc.brick_hit),   0);
        check({tag, "_hx"},    32'(rc.hit_x),       0);
        check({tag, "_hy"},    32'(rc.hit_y),       0);
        check({tag, "_h"},     32'(rc.brick_h_hit), 0);
        check({tag, "_v"},     32'(rc.brick_v_hit), 0);
        check({tag, "_pad"},   32'(rc.paddle_hit),  0);
        check({tag, "_total"}, 32'(rc.hit_total),   0);
    endtask

    initial begin
        rc.ball_x = 11'd100;
        rc.ball_y = 10'd200;
        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        check_all_zero("reset");
        reset = 1'b0;

        // Brick strip y=200, x=100..106 against ball at (100,200)
        step(10'd100, 9'd200, 1, 1, 1, 0, 0);
        check("lat1_hit", 32'(rc.brick_hit), 0);
        step(10'd101, 9'd200, 1, 1, 1, 0, 0);
        check("first_hit",   32'(rc.brick_hit),   1);
        check("first_hx",    32'(rc.hit_x),       100);
        check("first_hy",    32'(rc.hit_y),       200);
        check("first_h",     32'(rc.brick_h_hit), 1);
        check("first_v",     32'(rc.brick_v_hit), 1);
        check("first_total", 32'(rc.hit_total),   1);
        for (int x = 102; x <= 106; x++) begin
            step(10'(x), 9'd200, 1, 1, 1, 0, 0);
            check("strip_nohit", 32'(rc.brick_hit), 0);
        end
        idle(1'b0);
        check("strip_total", 32'(rc.hit_total), 1);

        // Second overlap in the same window
        step(10'd103, 9'd203, 1, 1, 1, 0, 0);
        idle(1'b0);
        check("second_hit", 32'(rc.brick_hit),   0);
        check("second_hx",  32'(rc.hit_x),       100);
        check("second_h",   32'(rc.brick_h_hit), 1);
        step(10'd50, 9'd50, 1, 1, 0, 1, 0);
        idle(1'b0);
        check("paddle_set", 32'(rc.paddle_hit), 1);

        // Refresh clears flags; hit coordinate holds
        idle(1'b1);
        check("tick_h",   32'(rc.brick_h_hit), 0);
        check("tick_v",   32'(rc.brick_v_hit), 0);
        check("tick_pad", 32'(rc.paddle_hit),  0);
        check("tick_hx",  32'(rc.hit_x),       100);
        step(10'd104, 9'd203, 1, 1, 1, 0, 0);
        idle(1'b0);
        check("win2_hit",   32'(rc.brick_hit),   1);
        check("win2_hx",    32'(rc.hit_x),       104);
        check("win2_hy",    32'(rc.hit_y),       203);
        check("win2_h",     32'(rc.brick_h_hit), 0);
        check("win2_v",     32'(rc.brick_v_hit), 0);
        check("win2_total", 32'(rc.hit_total),   2);

        // Tick coincident with stage-1 overlap at right edge x=107
        step(10'd107, 9'd201, 1, 1, 1, 0, 0);
        idle(1'b1);
        check("coinc_hit",   32'(rc.brick_hit),   1);
        check("coinc_h",     32'(rc.brick_h_hit), 1);
        check("coinc_v",     32'(rc.brick_v_hit), 0);
        check("coinc_hx",    32'(rc.hit_x),       107);
        check("coinc_total", 32'(rc.hit_total),   3);
        step(10'd100, 9'd200, 1, 1, 1, 0, 0);
        idle(1'b0);
        check("locked_hit", 32'(rc.brick_hit), 0);
        check("locked_v",   32'(rc.brick_v_hit), 1);
        check("locked_hx",  32'(rc.hit_x),     107);

        // Overlap during blanking is ignored
        idle(1'b1);
        step(10'd100, 9'd200, 0, 1, 1, 1, 0);
        idle(1'b0);
        check("blank_hit",   32'(rc.brick_hit),   0);
        check("blank_h",     32'(rc.brick_h_hit), 0);
        check("blank_pad",   32'(rc.paddle_hit),  0);
        check("blank_total", 32'(rc.hit_total),   3);

        // 300 windows, one overlap each: counter saturates
        exp_total = 3;
        for (int i = 0; i < 300; i++) begin
            step(10'd104, 9'd203, 1, 1, 1, 0, 0);
            idle(1'b0);
            if (exp_total < 255) exp_total++;
            if (i == 250) check("sat_254", 32'(rc.hit_total), 254);
            if (i == 251) check("sat_255", 32'(rc.hit_total), 255);
            if (i == 299) check("sat_pulse", 32'(rc.brick_hit), 1);
            idle(1'b1);
        end
        check("sat_final", 32'(rc.hit_total), 32'(exp_total));

        // Reset one cycle after an overlap sample
        step(10'd104, 9'd203, 1, 1, 1, 0, 0);
        reset = 1'b1;
        idle(1'b0);
        check_all_zero("midrst");
        reset = 1'b0;
        step(10'd100, 9'd200, 1, 1, 1, 0, 0);
        check("postrst_nohit", 32'(rc.brick_hit), 0);
        idle(1'b0);
        check("postrst_hit",   32'(rc.brick_hit), 1);
        check("postrst_total", 32'(rc.hit_total), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/raster_collision.md
RASTER_COLLISION -- requirements
Module: raster_collision

Interface
REQ-001 Parameter BALL_W, default 8: ball width in pixels, used for horizontal-edge classification.
REQ-002 Parameter BALL_H, default 7: ball height in pixels, used for vertical-edge classification.
REQ-003 CLOCK_50  in  1: system clock; single clock domain; all state updates on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 pixel_x  in  10: current raster column from the video driver.
REQ-006 pixel_y  in  9: current raster row from the video driver.
REQ-007 blank_n  in  1: high while the raster is in the visible region.
REQ-008 ball_on / brick_on / paddle_on  in  1 each: per-pixel draw strobes, combinational on pixel_x/pixel_y.
REQ-009 ball_x  in  11, ball_y  in  10: ball top-left position.
REQ-010 refresh_tick  in  1: one-cycle pulse marking a ball-move window boundary.
REQ-011 brick_hit  out  1: one-cycle pulse to the brick array on the first brick overlap in a window.
REQ-012 hit_x  out  10, hit_y  out  9: pixel coordinate captured with brick_hit.
REQ-013 brick_h_hit / brick_v_hit  out  1 each: sticky per-window edge flags to the ball block.
REQ-014 paddle_hit  out  1: sticky per-window ball/paddle overlap flag.
REQ-015 hit_total  out  8: saturating count of brick_hit pulses since reset.

Function
REQ-016 Stage 1 SHALL register the following one cycle after sampling: ov_brick = blank_n & ball_on & brick_on; ov_pad = blank_n & ball_on & paddle_on; the sampled pixel_x/pixel_y; and the edge tags.
REQ-017 Edge tag h SHALL be set when pixel_x == ball_x or pixel_x == ball_x+BALL_W-1, using 11-bit compares with pixel_x zero-extended.
REQ-018 Edge tag v SHALL be set when pixel_y == ball_y or pixel_y == ball_y+BALL_H-1, using 10-bit compares.
REQ-019 The FSM SHALL have two states, ARMED and LOCKED; reset enters ARMED.
REQ-020 In ARMED, a stage-1 ov_brick SHALL assert brick_hit for exactly one cycle, load hit_x/hit_y from the stage-1 coordinate in that same cycle, and transition to LOCKED.
REQ-021 Total latency from the overlapping pixel sample to brick_hit high SHALL be 2 cycles.
REQ-022 In LOCKED, brick_hit SHALL stay low; hit_x/hit_y SHALL hold; edge and paddle flags SHALL keep accumulating.
REQ-023 On refresh_tick, the FSM SHALL go to ARMED, and brick_h_hit, brick_v_hit and paddle_hit SHALL clear.
REQ-024 Edge and paddle flags SHALL be set by any stage-1 ov_brick tagged h/v, or by ov_pad, respectively.
REQ-025 If refresh_tick coincides with a stage-1 overlap, the overlap SHALL be treated as the first event of the new window: flags take that overlap's values, brick_hit pulses, and the FSM ends in LOCKED.
REQ-026 hit_x/hit_y SHALL hold their values between captures, including across refresh_tick.
REQ-027 hit_total SHALL increment on each brick_hit and saturate at 255.
REQ-028 Overlaps with blank_n low SHALL be ignored entirely.

Reset
REQ-029 While reset is high, all outputs SHALL be 0, the FSM SHALL be ARMED, and the stage-1 registers SHALL be 0; the first valid overlap is sampled in the cycle after reset deasserts.
REQ-030 Reset asserted mid-window SHALL discard any in-flight stage-1 overlap; no brick_hit is produced from it.

Verification
REQ-031 ball_x=100, ball_y=200, brick_on high over x=100..106, y=200, blank_n=1 -> a single brick_hit 2 cycles after x=100; hit_x=100, hit_y=200; brick_h_hit=1, brick_v_hit=1; hit_total=1.
REQ-032 Second overlap at x=103, y=203 in the same window -> no brick_hit; hit_x stays 100; brick_h_hit stays 1.
REQ-033 refresh_tick, then a new overlap at x=104, y=203 -> flags clear; brick_hit pulses with hit_x=104; brick_h_hit=0, brick_v_hit=0.
REQ-034 refresh_tick in the same cycle as a stage-1 overlap at an h-edge -> brick_hit=1, brick_h_hit=1, FSM=LOCKED.
REQ-035 300 windows, each with one overlap -> hit_total=255; ball/brick overlap with blank_n=0 -> no response.
REQ-036 Reset asserted 1 cycle after an overlap sample -> brick_hit never pulses; all outputs 0 on the next cycle.
